// File: rtl/demux1to16_wb.sv
// Write-back register bank: one WIDTH-bit write per cycle steered into one of 16 entries,
// through a single pending stage that can be stalled by hold without losing the request.
module demux1to16_wb #(
    parameter int                 WIDTH     = 64,
    parameter int                 ZERO_IDX  = 15,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_sel,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  hold,
    output logic [16*WIDTH-1:0]   q,
    output logic [15:0]           wr_onehot,
    output logic                  wr_done
);

    localparam logic [3:0] ZSEL = 4'(ZERO_IDX);

    logic             pend_valid_q, pend_valid_d;
    logic [3:0]       pend_sel_q;
    logic [WIDTH-1:0] pend_data_q;
    logic [15:0]      wr_onehot_q, wr_onehot_d;
    logic             wr_done_q;
    logic             accept, commit;

    assign in_ready = !pend_valid_q || !hold;
    assign accept   = in_valid && in_ready;
    assign commit   = pend_valid_q && !hold;

    // Commit and accept may coincide: the old entry drains while the new one loads.
    always_comb begin
        pend_valid_d = pend_valid_q;
        if (accept)
            pend_valid_d = 1'b1;
        else if (commit)
            pend_valid_d = 1'b0;
        wr_onehot_d = '0;
        if (commit && pend_sel_q != ZSEL)
            wr_onehot_d = 16'd1 << pend_sel_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_valid_q <= 1'b0;
            pend_sel_q   <= '0;
            pend_data_q  <= '0;
            wr_onehot_q  <= '0;
            wr_done_q    <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
            if (accept) begin
                pend_sel_q  <= in_sel;
                pend_data_q <= in_data;
            end
            wr_onehot_q <= wr_onehot_d;
            wr_done_q   <= commit;
        end
    end

    assign wr_onehot = wr_onehot_q;
    assign wr_done   = wr_done_q;

    for (genvar i = 0; i < 16; i++) begin : g_entry
        if (i == ZERO_IDX) begin : g_zero
            assign q[i*WIDTH +: WIDTH] = '0;
        end else begin : g_reg
            logic [WIDTH-1:0] entry_q;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    entry_q <= RESET_VAL;
                else if (commit && pend_sel_q == 4'(i))
                    entry_q <= pend_data_q;
            end
            assign q[i*WIDTH +: WIDTH] = entry_q;
        end
    end

endmodule

// File: tb/tb_demux1to16_wb.sv
// Directed bench for demux1to16_wb: reset, single/streamed writes, zero entry, stall, mid-op reset.
module tb_demux1to16_wb;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_sel;
    logic [63:0]     in_data;
    logic            hold;
    logic [1023:0]   q;
    logic [15:0]     wr_onehot;
    logic            wr_done;

    int checks = 0;
    int failures = 0;

    demux1to16_wb dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .hold      (hold),
        .q         (q),
        .wr_onehot (wr_onehot),
        .wr_done   (wr_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] ent(input int i);
        return q[i*64 +: 64];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] DATA_A = 64'hA5A5_0000_0000_0005;
    localparam logic [63:0] DATA_B = 64'hB6B6_0000_0000_0006;

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0; hold = 1'b0;
        #3;
        for (int i = 0; i < 16; i++) chk($sformatf("rst_q%0d", i), ent(i), 64'd0);
        tick(); tick();
        reset = 1'b1;
        #1;
        chk("rel_ready", 64'(in_ready), 64'd1);
        chk("rel_done", 64'(wr_done), 64'd0);
        chk("rel_onehot", 64'(wr_onehot), 64'd0);

        // single write
        in_valid = 1'b1; in_sel = 4'd3; in_data = 64'hDEAD_BEEF_0000_0003;
        tick();
        in_valid = 1'b0;
        chk("single_nobypass", ent(3), 64'd0);
        chk("single_done0", 64'(wr_done), 64'd0);
        tick();
        chk("single_q3", ent(3), 64'hDEAD_BEEF_0000_0003);
        chk("single_done", 64'(wr_done), 64'd1);
        chk("single_onehot", 64'(wr_onehot), 64'h0008);
        chk("single_q2", ent(2), 64'd0);
        tick();
        chk("single_pulse", 64'(wr_done), 64'd0);
        chk("single_oh_clr", 64'(wr_onehot), 64'd0);

        // streaming writes 0..14
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1; in_sel = 4'(i); in_data = 64'(i) * 64'h1111;
            chk($sformatf("stream_ready%0d", i), 64'(in_ready), 64'd1);
            tick();
            if (i > 0) begin
                chk($sformatf("stream_done%0d", i - 1), 64'(wr_done), 64'd1);
                chk($sformatf("stream_oh%0d", i - 1), 64'(wr_onehot), 64'd1 << (i - 1));
            end
        end
        in_valid = 1'b0;
        tick();
        chk("stream_done14", 64'(wr_done), 64'd1);
        tick();
        chk("stream_end", 64'(wr_done), 64'd0);
        for (int i = 0; i < 15; i++) chk($sformatf("stream_q%0d", i), ent(i), 64'(i) * 64'h1111);

        // hardwired zero entry
        in_valid = 1'b1; in_sel = 4'd15; in_data = '1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("zero_done", 64'(wr_done), 64'd1);
        chk("zero_onehot", 64'(wr_onehot), 64'd0);
        chk("zero_q15", ent(15), 64'd0);
        tick();

        // stall
        in_valid = 1'b1; in_sel = 4'd5; in_data = DATA_A;
        tick();
        hold = 1'b1; in_sel = 4'd6; in_data = DATA_B;
        #1;
        chk("stall_ready0", 64'(in_ready), 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stall_ready%0d", c), 64'(in_ready), 64'd0);
            chk($sformatf("stall_q5_%0d", c), ent(5), 64'h5555);
            chk($sformatf("stall_done%0d", c), 64'(wr_done), 64'd0);
        end
        hold = 1'b0;
        #1;
        chk("stall_ready_rel", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("stall_q5", ent(5), DATA_A);
        chk("stall_done_a", 64'(wr_done), 64'd1);
        chk("stall_oh_a", 64'(wr_onehot), 64'h0020);
        chk("stall_q6_old", ent(6), 64'h6666);
        tick();
        chk("stall_q6", ent(6), DATA_B);
        chk("stall_oh_b", 64'(wr_onehot), 64'h0040);
        chk("stall_q5_keep", ent(5), DATA_A);
        tick();
        chk("stall_end", 64'(wr_done), 64'd0);

        // reset mid-operation
        in_valid = 1'b1; in_sel = 4'd7; in_data = 64'h1234;
        tick();
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("mid_q7", ent(7), 64'd0);
        chk("mid_q5", ent(5), 64'd0);
        chk("mid_done", 64'(wr_done), 64'd0);
        reset = 1'b1;
        tick();
        chk("mid_nocommit_done", 64'(wr_done), 64'd0);
        chk("mid_nocommit_q7", ent(7), 64'd0);
        chk("mid_ready", 64'(in_ready), 64'd1);
        tick();
        chk("mid_done2", 64'(wr_done), 64'd0);
        chk("mid_oh2", 64'(wr_onehot), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
